// File: rtl/ex_mem_skid_pkg.sv
// Shared widths, entry bundle and occupancy states for the EX/MEM skid stage.
package ex_mem_skid_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] wdata;
        logic [REGW-1:0] rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
    } ex_mem_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/ex_mem_skid_entry_reg.sv
// One EX/MEM entry register; loads only when enabled so idle cycles do not toggle it.
module skid_entry_reg
    import ex_mem_skid_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  ex_mem_entry_t d,
    output ex_mem_entry_t q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline stage with a two-deep skid buffer (head H drives *_mem, S holds overflow).
module ex_mem_skid
    import ex_mem_skid_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_ex,
    input  logic            alu_ready,
    input  logic [XLEN-1:0] alu_result_ex,
    input  logic            branch_alu,
    input  logic [XLEN-1:0] write_data_ex,
    input  logic [REGW-1:0] rd_ex,
    input  logic            reg_write_ex,
    input  logic            mem_read_ex,
    input  logic            mem_write_ex,
    input  logic            flush,
    input  logic            data_ready_mem,
    output logic            stall_ex,
    output logic            valid_mem,
    output logic [XLEN-1:0] alu_result_mem,
    output logic [XLEN-1:0] write_data_mem,
    output logic [REGW-1:0] rd_mem,
    output logic            reg_write_mem,
    output logic            mem_read_mem,
    output logic            mem_write_mem,
    output logic            branch_mem,
    output logic            fwd_valid
);

    skid_state_t   state, state_next;
    ex_mem_entry_t in_entry, h_d, h_q, s_q;
    logic          accept, pop;
    logic          load_h, load_s, h_from_s;

    assign in_entry = '{result:    alu_result_ex,
                        wdata:     write_data_ex,
                        rd:        rd_ex,
                        reg_write: reg_write_ex,
                        mem_read:  mem_read_ex,
                        mem_write: mem_write_ex,
                        branch:    branch_alu};

    assign valid_mem = (state != EMPTY);
    assign accept    = valid_ex & alu_ready & (state != FULL);
    assign pop       = valid_mem & data_ready_mem;
    assign stall_ex  = valid_ex & (~alu_ready | (state == FULL));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_h     = 1'b0;
        load_s     = 1'b0;
        h_from_s   = 1'b0;
        if (flush) begin
            // Redirect wins: drop everything buffered and anything arriving now.
            state_next = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state_next = ONE;
                        load_h     = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        load_h = 1'b1;
                    end else if (accept) begin
                        state_next = FULL;
                        load_s     = 1'b1;
                    end else if (pop) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_next = ONE;
                        load_h     = 1'b1;
                        h_from_s   = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    assign h_d = h_from_s ? s_q : in_entry;

    skid_entry_reg u_head (
        .clk  (clk),
        .rst  (rst),
        .load (load_h),
        .d    (h_d),
        .q    (h_q)
    );

    skid_entry_reg u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (load_s),
        .d    (in_entry),
        .q    (s_q)
    );

    // Control bits are gated so a flushed stage never leaks stale writes downstream.
    assign alu_result_mem = h_q.result;
    assign write_data_mem = h_q.wdata;
    assign rd_mem         = h_q.rd;
    assign reg_write_mem  = valid_mem & h_q.reg_write;
    assign mem_read_mem   = valid_mem & h_q.mem_read;
    assign mem_write_mem  = valid_mem & h_q.mem_write;
    assign branch_mem     = valid_mem & h_q.branch;
    assign fwd_valid      = reg_write_mem & (h_q.rd != '0);

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed bench for ex_mem_skid: reset, streaming, backpressure, FPU wait, flush, forwarding.
module tb_ex_mem_skid;
    import ex_mem_skid_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_ex, alu_ready, branch_alu;
    logic [XLEN-1:0] alu_result_ex, write_data_ex;
    logic [REGW-1:0] rd_ex;
    logic            reg_write_ex, mem_read_ex, mem_write_ex;
    logic            flush, data_ready_mem;
    logic            stall_ex, valid_mem;
    logic [XLEN-1:0] alu_result_mem, write_data_mem;
    logic [REGW-1:0] rd_mem;
    logic            reg_write_mem, mem_read_mem, mem_write_mem, branch_mem, fwd_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_mem_skid dut (
        .clk            (clk),
        .rst            (rst),
        .valid_ex       (valid_ex),
        .alu_ready      (alu_ready),
        .alu_result_ex  (alu_result_ex),
        .branch_alu     (branch_alu),
        .write_data_ex  (write_data_ex),
        .rd_ex          (rd_ex),
        .reg_write_ex   (reg_write_ex),
        .mem_read_ex    (mem_read_ex),
        .mem_write_ex   (mem_write_ex),
        .flush          (flush),
        .data_ready_mem (data_ready_mem),
        .stall_ex       (stall_ex),
        .valid_mem      (valid_mem),
        .alu_result_mem (alu_result_mem),
        .write_data_mem (write_data_mem),
        .rd_mem         (rd_mem),
        .reg_write_mem  (reg_write_mem),
        .mem_read_mem   (mem_read_mem),
        .mem_write_mem  (mem_write_mem),
        .branch_mem     (branch_mem),
        .fwd_valid      (fwd_valid)
    );

    task automatic applyStimulus(input logic v, input logic ar, input logic [31:0] res,
                                 input logic [31:0] wd, input logic [4:0] rd,
                                 input logic rw, input logic mr, input logic mw,
                                 input logic br, input logic ready);
        valid_ex       = v;
        alu_ready      = ar;
        alu_result_ex  = res;
        write_data_ex  = wd;
        rd_ex          = rd;
        reg_write_ex   = rw;
        mem_read_ex    = mr;
        mem_write_ex   = mw;
        branch_alu     = br;
        data_ready_mem = ready;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkEmptyCtrl(input string tag);
        checkOutput({tag, "_valid"}, 32'(valid_mem), 32'd0);
        checkOutput({tag, "_ctrl"},
                    32'({reg_write_mem, mem_read_mem, mem_write_mem, branch_mem, fwd_valid}), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        checkEmptyCtrl("por");
        checkOutput("por_result", alu_result_mem, 32'h0);

        // Fill to FULL, then reset for two cycles.
        applyStimulus(1, 1, 32'h55, 32'h66, 5'd3, 1, 1, 0, 1, 0);
        tick();
        tick();
        checkOutput("full_stall", 32'(stall_ex), 32'd1);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkEmptyCtrl("rst_full");
        checkOutput("rst_full_stall", 32'(stall_ex), 32'd0);
        checkOutput("rst_full_result", alu_result_mem, 32'h0);
        checkOutput("rst_full_rd", 32'(rd_mem), 32'd0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_stall_inputs", 32'(stall_ex), 32'd1);

        // Streaming with memory always ready.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 1, 32'(i * 4), 32'(i + 100), 5'd1, 0, 0, (i % 2 == 1), 0, 1);
            checkOutput($sformatf("stream%0d_stall", i), 32'(stall_ex), 32'd0);
            tick();
            checkOutput($sformatf("stream%0d_valid", i), 32'(valid_mem), 32'd1);
            checkOutput($sformatf("stream%0d_result", i), alu_result_mem, 32'(i * 4));
            checkOutput($sformatf("stream%0d_memw", i), 32'(mem_write_mem), 32'(i % 2 == 1));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        checkOutput("stream_drain_valid", 32'(valid_mem), 32'd0);

        // Backpressure: A, B, C with memory stalled.
        applyStimulus(1, 1, 32'h11, 32'hA0, 5'd2, 1, 0, 0, 0, 0);
        checkOutput("bp_a_stall", 32'(stall_ex), 32'd0);
        tick();
        applyStimulus(1, 1, 32'h22, 32'hB0, 5'd4, 0, 0, 1, 1, 0);
        checkOutput("bp_b_stall", 32'(stall_ex), 32'd0);
        tick();
        applyStimulus(1, 1, 32'h33, 32'hC0, 5'd6, 0, 1, 0, 0, 0);
        checkOutput("bp_c_stall", 32'(stall_ex), 32'd1);
        tick();
        checkOutput("bp_hold_stall", 32'(stall_ex), 32'd1);
        checkOutput("bp_head_a", alu_result_mem, 32'h11);
        applyStimulus(1, 1, 32'h33, 32'hC0, 5'd6, 0, 1, 0, 0, 1);
        checkOutput("bp_ready_stall", 32'(stall_ex), 32'd1);
        tick();
        checkOutput("bp_head_b", alu_result_mem, 32'h22);
        checkOutput("bp_head_b_wdata", write_data_mem, 32'hB0);
        checkOutput("bp_head_b_branch", 32'(branch_mem), 32'd1);
        checkOutput("bp_after_pop_stall", 32'(stall_ex), 32'd0);
        tick();
        checkOutput("bp_head_c", alu_result_mem, 32'h33);
        checkOutput("bp_head_c_memr", 32'(mem_read_mem), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        checkOutput("bp_drain_valid", 32'(valid_mem), 32'd0);

        // FPU busy for five cycles.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 32'hDEAD, 0, 5'd7, 1, 0, 0, 0, 1);
            checkOutput($sformatf("fpu%0d_stall", i), 32'(stall_ex), 32'd1);
            tick();
            checkOutput($sformatf("fpu%0d_valid", i), 32'(valid_mem), 32'd0);
        end
        applyStimulus(1, 1, 32'h3F800000, 0, 5'd7, 1, 0, 0, 0, 1);
        checkOutput("fpu_done_stall", 32'(stall_ex), 32'd0);
        tick();
        checkOutput("fpu_result", alu_result_mem, 32'h3F800000);
        checkOutput("fpu_valid", 32'(valid_mem), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        checkOutput("fpu_single", 32'(valid_mem), 32'd0);

        // Flush while FULL with a new op presented.
        applyStimulus(1, 1, 32'hA1, 0, 5'd1, 1, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 32'hA2, 0, 5'd2, 1, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 32'hA3, 0, 5'd3, 1, 0, 0, 0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkEmptyCtrl("flush_full");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        checkOutput("flush_full_gone", 32'(valid_mem), 32'd0);

        // Flush in ONE coincident with a would-be accept.
        applyStimulus(1, 1, 32'hB1, 0, 5'd1, 1, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 32'hB2, 0, 5'd2, 1, 0, 0, 0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkEmptyCtrl("flush_one");
        tick();
        checkOutput("flush_one_gone", 32'(valid_mem), 32'd0);

        // Forwarding qualification on rd.
        applyStimulus(1, 1, 32'hC1, 0, 5'd0, 1, 0, 0, 0, 0);
        tick();
        checkOutput("fwd_rd0_valid", 32'(valid_mem), 32'd1);
        checkOutput("fwd_rd0", 32'(fwd_valid), 32'd0);
        applyStimulus(1, 1, 32'hC2, 0, 5'd5, 1, 0, 0, 0, 1);
        tick();
        checkOutput("fwd_rd5_rd", 32'(rd_mem), 32'd5);
        checkOutput("fwd_rd5", 32'(fwd_valid), 32'd1);
        checkOutput("fwd_rd5_result", alu_result_mem, 32'hC2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        checkOutput("fwd_after_pop", 32'(fwd_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
